// File: rtl/two_chan_rr_arb_pkg.sv
// two_chan_rr_arb_pkg: source encodings and default payload width for the two-channel arbiter
package two_chan_rr_arb_pkg;
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/two_chan_rr_arb_rr_grant2.sv
// rr_grant2: combinational two-way round-robin grant, ties go to the channel not granted last
module rr_grant2
  import two_chan_rr_arb_pkg::*;
(
  input  logic a_valid,
  input  logic b_valid,
  input  logic last_grant,
  output logic grant_a,
  output logic grant_b
);
  assign grant_a = a_valid && (!b_valid || last_grant == SRC_B);
  assign grant_b = b_valid && (!a_valid || last_grant == SRC_A);
endmodule

// File: rtl/two_chan_rr_arb.sv
// two_chan_rr_arb: round-robin merge of two valid/ready channels into one registered output slot
module two_chan_rr_arb
  import two_chan_rr_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_sel;
  logic             r_out_valid;
  logic             r_last_grant;
  logic             w_load;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_xfer;
  logic [WIDTH-1:0] w_mux;

  rr_grant2 u_grant (
    .a_valid   (a_valid),
    .b_valid   (b_valid),
    .last_grant(r_last_grant),
    .grant_a   (w_grant_a),
    .grant_b   (w_grant_b)
  );

  // rst_n gating keeps both readies low while the empty slot is held in reset
  assign w_load  = rst_n && (!r_out_valid || out_ready);
  assign a_ready = w_grant_a && w_load;
  assign b_ready = w_grant_b && w_load;
  assign w_xfer  = a_ready || b_ready;
  assign w_mux   = w_grant_b ? b_data : a_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data   <= '0;
      r_out_sel    <= SRC_A;
      r_out_valid  <= 1'b0;
      r_last_grant <= SRC_B;
    end else if (w_load) begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data   <= w_mux;
        r_out_sel    <= w_grant_b;
        r_last_grant <= w_grant_b;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;
endmodule
